hdmi_audio_decim: RTL and testbench

Box-filter decimator in front of the HDMI transmitter's audio input. It accumulates signed stereo PCM delivered at an arbitrary rate via sample_en. On each samplerate strobe coming back from the HDMI top, it outputs the mean of the window just closed. It feeds audio_l/audio_r of the HDMI top and consumes its samplerate_stb, so core audio is band-limited rather than point-sampled at the HDMI sample rate.

---
 rtl/hdmi_audio_decim.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_audio_decim.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_audio_decim.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_audio_decim
//  Brief    : Box-filter decimator for stereo PCM feeding the HDMI audio
//             input. Sums samples between window-close strobes, then
//             divides by the sample count to produce the window mean.
//  Revision : 1.0  initial release
// ============================================================================
module hdmi_audio_decim #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 28
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_en,
  input  logic [IN_W-1:0] in_l,
  input  logic [IN_W-1:0] in_r,
  input  logic            sample_stb,
  output logic [IN_W-1:0] out_l,
  output logic [IN_W-1:0] out_r,
  output logic            out_valid,
  output logic            busy,
  output logic            overrun,
  output logic            dropped
);

  localparam int CNT_W  = ACC_W - IN_W;
  localparam int ITER_W = $clog2(ACC_W);

  localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] c_iter_one  = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] c_iter_last = ITER_W'(ACC_W - 1);
  localparam logic [ACC_W-1:0]  c_acc_one   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W-1:0]   c_in_one    = {{(IN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;

  // Running window sums and sample count
  logic [ACC_W-1:0]  r_acc_l, r_acc_r;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dropped;

  // Divider working registers: r_quo_* starts as |dividend| and shifts into
  // the quotient; the remainder never exceeds the divisor so CNT_W bits hold it.
  logic [ACC_W-1:0]  r_quo_l, r_quo_r;
  logic [CNT_W-1:0]  r_rem_l, r_rem_r;
  logic              r_neg_l, r_neg_r;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [ITER_W-1:0] r_iter;

  logic [IN_W-1:0]   r_out_l, r_out_r;
  logic              r_out_valid, r_busy, r_overrun;

  logic [ACC_W-1:0]  w_sext_l, w_sext_r;
  logic [ACC_W-1:0]  w_abs_l, w_abs_r;
  logic [CNT_W:0]    w_trial_l, w_trial_r;
  logic [CNT_W-1:0]  w_diff_l, w_diff_r;
  logic              w_ge_l, w_ge_r;
  logic [IN_W-1:0]   w_res_l, w_res_r;
  logic              w_accept;

  assign w_accept = sample_stb && (r_state == S_IDLE);

  assign w_sext_l = {{(ACC_W-IN_W){in_l[IN_W-1]}}, in_l};
  assign w_sext_r = {{(ACC_W-IN_W){in_r[IN_W-1]}}, in_r};

  assign w_abs_l = r_acc_l[ACC_W-1] ? (~r_acc_l + c_acc_one) : r_acc_l;
  assign w_abs_r = r_acc_r[ACC_W-1] ? (~r_acc_r + c_acc_one) : r_acc_r;

  // One restoring-division step: bring down the next dividend bit, subtract
  // the divisor when it fits. The difference is below the divisor, so the
  // low CNT_W bits of the subtraction are exact.
  assign w_trial_l = {r_rem_l, r_quo_l[ACC_W-1]};
  assign w_trial_r = {r_rem_r, r_quo_r[ACC_W-1]};
  assign w_ge_l    = (w_trial_l >= {1'b0, r_div_cnt});
  assign w_ge_r    = (w_trial_r >= {1'b0, r_div_cnt});
  assign w_diff_l  = w_trial_l[CNT_W-1:0] - r_div_cnt;
  assign w_diff_r  = w_trial_r[CNT_W-1:0] - r_div_cnt;

  // Quotient magnitude is at most 2^(IN_W-1), so the low IN_W bits suffice;
  // negating 0x8000 yields -32768 exactly.
  assign w_res_l = r_neg_l ? (~r_quo_l[IN_W-1:0] + c_in_one) : r_quo_l[IN_W-1:0];
  assign w_res_r = r_neg_r ? (~r_quo_r[IN_W-1:0] + c_in_one) : r_quo_r[IN_W-1:0];

  // Accumulate samples; an accepted strobe restarts the window, seeding it
  // with a coincident sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_cnt     <= '0;
      r_dropped <= 1'b0;
    end else if (w_accept) begin
      if (sample_en) begin
        r_acc_l <= w_sext_l;
        r_acc_r <= w_sext_r;
        r_cnt   <= c_cnt_one;
      end else begin
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_cnt   <= '0;
      end
    end else if (sample_en) begin
      if (r_cnt != c_cnt_max) begin
        r_acc_l <= r_acc_l + w_sext_l;
        r_acc_r <= r_acc_r + w_sext_r;
        r_cnt   <= r_cnt + c_cnt_one;
      end else begin
        r_dropped <= 1'b1;
      end
    end
  end

  // Window-close sequencer: latch, divide both channels in lockstep, sign.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_quo_l     <= '0;
      r_quo_r     <= '0;
      r_rem_l     <= '0;
      r_rem_r     <= '0;
      r_neg_l     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_cnt   <= '0;
      r_iter      <= '0;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (sample_stb && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (sample_stb) begin
            r_quo_l   <= w_abs_l;
            r_quo_r   <= w_abs_r;
            r_neg_l   <= r_acc_l[ACC_W-1];
            r_neg_r   <= r_acc_r[ACC_W-1];
            r_div_cnt <= r_cnt;
            r_rem_l   <= '0;
            r_rem_r   <= '0;
            r_iter    <= '0;
            if (r_cnt == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_quo_l <= {r_quo_l[ACC_W-2:0], w_ge_l};
          r_quo_r <= {r_quo_r[ACC_W-2:0], w_ge_r};
          r_rem_l <= w_ge_l ? w_diff_l : w_trial_l[CNT_W-1:0];
          r_rem_r <= w_ge_r ? w_diff_r : w_trial_r[CNT_W-1:0];
          r_iter  <= r_iter + c_iter_one;
          if (r_iter == c_iter_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          // An empty window keeps the previous output but still pulses valid.
          if (r_div_cnt != '0) begin
            r_out_l <= w_res_l;
            r_out_r <= w_res_r;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_l     = r_out_l;
  assign out_r     = r_out_r;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_audio_decim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdmi_audio_decim
//  Brief    : Directed self-checking bench for hdmi_audio_decim.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hdmi_audio_decim;

  logic        clk;
  logic        reset_n;
  logic        sample_en;
  logic [15:0] in_l, in_r;
  logic        sample_stb;
  logic [15:0] out_l, out_r;
  logic        out_valid, busy, overrun, dropped;

  int n_pass;
  int n_total;

  hdmi_audio_decim #(.IN_W(16), .ACC_W(28)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .in_l       (in_l),
    .in_r       (in_r),
    .sample_stb (sample_stb),
    .out_l      (out_l),
    .out_r      (out_r),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic feed(input logic signed [15:0] l, input logic signed [15:0] r);
    sample_en = 1'b1;
    in_l      = l;
    in_r      = r;
    step();
    sample_en = 1'b0;
  endtask

  // Pulse the strobe for one edge, then wait (bounded) for out_valid.
  // lat is the number of edges after the accepting edge; -1 if none came.
  task automatic close_window(input bit keep_en, output int lat, output int busy_cyc);
    lat        = -1;
    busy_cyc   = 0;
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    if (!keep_en) sample_en = 1'b0;
    if (busy) busy_cyc++;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy) busy_cyc++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    sample_en  = 1'b0;
    sample_stb = 1'b0;
    in_l       = '0;
    in_r       = '0;
    run(3);
    n_total++; if (out_l !== 16'd0) $display("FAIL reset_out_l: got %0d expected 0", out_l); else n_pass++;
    n_total++; if (out_r !== 16'd0) $display("FAIL reset_out_r: got %0d expected 0", out_r); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %b expected 0", dropped); else n_pass++;
    reset_n = 1'b1;
    run(2);
  endtask

  task automatic test_steady();
    int lat, bc;
    sample_en = 1'b1;
    in_l      = 16'sd1000;
    in_r      = -16'sd1000;
    run(846);
    for (int w = 0; w < 2; w++) begin
      close_window(1'b1, lat, bc);
      n_total++; if (lat !== 29) $display("FAIL steady_latency[%0d]: got %0d expected 29", w, lat); else n_pass++;
      n_total++; if (bc !== 28) $display("FAIL steady_busy_cycles[%0d]: got %0d expected 28", w, bc); else n_pass++;
      n_total++; if ($signed(out_l) !== 16'sd1000) $display("FAIL steady_out_l[%0d]: got %0d expected 1000", w, $signed(out_l)); else n_pass++;
      n_total++; if ($signed(out_r) !== -16'sd1000) $display("FAIL steady_out_r[%0d]: got %0d expected -1000", w, $signed(out_r)); else n_pass++;
      run(845);
    end
    n_total++; if (overrun !== 1'b0) $display("FAIL steady_overrun: got %b expected 0", overrun); else n_pass++;
    sample_en = 1'b0;
    close_window(1'b0, lat, bc);
  endtask

  task automatic test_truncate();
    int lat, bc;
    feed(16'sd3, -16'sd3);
    feed(16'sd4, -16'sd4);
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== 16'sd3) $display("FAIL trunc_out_l: got %0d expected 3", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== -16'sd3) $display("FAIL trunc_out_r: got %0d expected -3", $signed(out_r)); else n_pass++;
    for (int i = 0; i < 10; i++) feed(-16'sd32768, 16'sd7);
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== -16'sd32768) $display("FAIL min_out_l: got %0d expected -32768", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== 16'sd7) $display("FAIL min_out_r: got %0d expected 7", $signed(out_r)); else n_pass++;
    feed(-16'sd7, 16'sd7);
    feed(16'sd0, 16'sd0);
    feed(16'sd0, 16'sd0);
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== -16'sd2) $display("FAIL third_out_l: got %0d expected -2", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== 16'sd2) $display("FAIL third_out_r: got %0d expected 2", $signed(out_r)); else n_pass++;
  endtask

  task automatic test_empty();
    int lat, bc;
    close_window(1'b0, lat, bc);
    n_total++; if (lat !== 1) $display("FAIL empty_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if (bc !== 0) $display("FAIL empty_busy_cycles: got %0d expected 0", bc); else n_pass++;
    n_total++; if ($signed(out_l) !== -16'sd2) $display("FAIL empty_hold_l: got %0d expected -2", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== 16'sd2) $display("FAIL empty_hold_r: got %0d expected 2", $signed(out_r)); else n_pass++;
  endtask

  task automatic test_coincident();
    int lat, bc;
    for (int i = 0; i < 3; i++) feed(16'sd100, -16'sd100);
    sample_en = 1'b1;
    in_l      = 16'sd500;
    in_r      = -16'sd500;
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== 16'sd100) $display("FAIL coinc_out_l: got %0d expected 100", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== -16'sd100) $display("FAIL coinc_out_r: got %0d expected -100", $signed(out_r)); else n_pass++;
    feed(16'sd300, -16'sd300);
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== 16'sd400) $display("FAIL next_out_l: got %0d expected 400", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== -16'sd400) $display("FAIL next_out_r: got %0d expected -400", $signed(out_r)); else n_pass++;
  endtask

  task automatic test_overrun();
    int lat, bc, pulses;
    feed(16'sd200, -16'sd200);
    feed(16'sd200, -16'sd200);
    pulses     = 0;
    sample_stb = 1'b1;
    step();
    for (int k = 1; k <= 39; k++) begin
      sample_stb = (k == 10);
      sample_en  = (k == 2) || (k == 4) || (k == 15) || (k == 17);
      in_l       = (k < 10) ? 16'sd800 : 16'sd500;
      in_r       = (k < 10) ? -16'sd800 : -16'sd500;
      step();
      if (out_valid) pulses++;
    end
    sample_stb = 1'b0;
    sample_en  = 1'b0;
    n_total++; if (pulses !== 1) $display("FAIL ovr_pulses: got %0d expected 1", pulses); else n_pass++;
    n_total++; if ($signed(out_l) !== 16'sd200) $display("FAIL ovr_first_l: got %0d expected 200", $signed(out_l)); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else n_pass++;
    close_window(1'b0, lat, bc);
    n_total++; if (lat !== 29) $display("FAIL ovr_latency: got %0d expected 29", lat); else n_pass++;
    n_total++; if ($signed(out_l) !== 16'sd650) $display("FAIL ovr_merged_l: got %0d expected 650", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== -16'sd650) $display("FAIL ovr_merged_r: got %0d expected -650", $signed(out_r)); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else n_pass++;
  endtask

  task automatic test_saturate_and_reset();
    int lat, bc, pulses;
    sample_en = 1'b1;
    in_l      = 16'sd32767;
    in_r      = -16'sd1;
    run(5000);
    sample_en = 1'b0;
    n_total++; if (dropped !== 1'b1) $display("FAIL sat_dropped: got %b expected 1", dropped); else n_pass++;
    close_window(1'b0, lat, bc);
    n_total++; if ($signed(out_l) !== 16'sd32767) $display("FAIL sat_out_l: got %0d expected 32767", $signed(out_l)); else n_pass++;
    n_total++; if ($signed(out_r) !== -16'sd1) $display("FAIL sat_out_r: got %0d expected -1", $signed(out_r)); else n_pass++;
    feed(16'sd10, 16'sd10);
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    run(5);
    reset_n = 1'b0;
    #1;
    n_total++; if (out_l !== 16'd0) $display("FAIL midrst_out_l: got %0d expected 0", out_l); else n_pass++;
    n_total++; if (out_r !== 16'd0) $display("FAIL midrst_out_r: got %0d expected 0", out_r); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL midrst_overrun: got %b expected 0", overrun); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL midrst_dropped: got %b expected 0", dropped); else n_pass++;
    run(2);
    reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL midrst_no_valid: got %0d expected 0", pulses); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_steady();
    test_truncate();
    test_empty();
    test_coincident();
    test_overrun();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
